// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Contents: fetch FSM state enum, data/address widths, PC step,
//           and the {pc, instr} entry carried through the skid FIFO.
package imem_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Purpose: 2-entry FIFO of {pc, instr}; head is a register, so outputs are registered.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: caller must never push into a full FIFO unless popping; flush wins over push/pop.
// Ports: clk, rst_n, push/push_entry, pop, flush in; count (0..2) and head out.
module fetch_skid_fifo
  import imem_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case (count)
        2'd0: begin
          if (push) begin
            head  <= push_entry;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= push_entry;
          end else if (push) begin
            tail  <= push_entry;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          // Full: the second entry slides into the head on a pop.
          if (pop) begin
            head <= tail;
            if (push) tail  <= push_entry;
            else      count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Purpose: fetch sequencer owning the PC; one word read per cycle into a 2-entry skid FIFO.
// Latency: fetch_en edge E0 -> first word valid after E2; redirect edge R -> target valid after R+2.
// Backpressure: if_ready low stops issue once 2 words are buffered; resumes at full rate.
// Ports: fetch_en/redirect_* control in; imem_addr out / imem_instr in to memory;
//        if_valid/if_ready/if_instr/if_pc to IF/ID; halted, err_misaligned, err_range status.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_BYTES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted,
  output logic               err_misaligned,
  output logic               err_range
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_v_q, inflight_v_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              err_mis_q, err_rng_q;
  logic              set_mis, set_rng;
  logic              flush, pop;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              issue_ok;
  fetch_entry_t      push_entry, head;

  assign pop        = if_valid & if_ready;
  assign push_entry = '{pc: inflight_pc_q, instr: imem_instr};
  // Words held or on their way, minus the one leaving this cycle, must leave room for one more.
  assign occ        = {1'b0, count} + {2'b0, inflight_v_q};
  assign issue_ok   = (occ <= (3'd1 + {2'b0, pop}));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_v_d  = 1'b0;
    inflight_pc_d = inflight_pc_q;
    flush         = 1'b0;
    set_mis       = 1'b0;
    set_rng       = 1'b0;

    unique case (state_q)
      IDLE: if (fetch_en) state_d = RUN;
      RUN: begin
        if (pc_q > LAST_WORD) begin
          set_rng = 1'b1;
          state_d = DRAIN;
        end else if (issue_ok) begin
          inflight_v_d  = 1'b1;
          inflight_pc_d = pc_q;
          pc_d          = pc_q + ADDR_W'(PC_STEP);
        end
      end
      DRAIN: if (count == 2'd0 && !inflight_v_q) state_d = HALT;
      HALT: ;
    endcase

    // A redirect overrides everything above, including the returning word and any pop.
    if (redirect_valid && (state_q == RUN || state_q == DRAIN)) begin
      flush        = 1'b1;
      inflight_v_d = 1'b0;
      set_rng      = 1'b0;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d    = redirect_pc;
        state_d = RUN;
      end else begin
        pc_d    = pc_q;
        set_mis = 1'b1;
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
      err_mis_q     <= 1'b0;
      err_rng_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
      if (set_mis) err_mis_q <= 1'b1;
      if (set_rng) err_rng_q <= 1'b1;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_v_q),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head       (head)
  );

  assign imem_addr      = pc_q;
  assign if_valid       = (count != 2'd0);
  assign if_instr       = head.instr;
  assign if_pc          = head.pc;
  assign halted         = (state_q == HALT);
  assign err_misaligned = err_mis_q;
  assign err_range      = err_rng_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios with exact cycle expectations,
// then a randomized run scored against an instruction-stream model
// (next expected PC, word contents from the memory image).
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        err_misaligned;
  logic        err_range;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [64];

  imem_fetch_ctrl #(.RESET_PC(32'h0), .MEM_BYTES(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .err_misaligned (err_misaligned),
    .err_range      (err_range)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory, one registered read per edge.
  always @(posedge clk) imem_instr <= mem[imem_addr[7:2]];

  task automatic check_dat(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return mem[pc[7:2]];
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] pc);
    check_dat({tag, "_vld"},   32'(if_valid), 32'd1);
    check_dat({tag, "_pc"},    if_pc, pc);
    check_dat({tag, "_instr"}, if_instr, word_at(pc));
  endtask

  task automatic check_reset_vals(input string tag);
    check_dat({tag, "_addr"},  imem_addr, 32'h0);
    check_dat({tag, "_vld"},   32'(if_valid), 32'd0);
    check_dat({tag, "_instr"}, if_instr, 32'h0);
    check_dat({tag, "_pc"},    if_pc, 32'h0);
    check_dat({tag, "_halt"},  32'(halted), 32'd0);
    check_dat({tag, "_emis"},  32'(err_misaligned), 32'd0);
    check_dat({tag, "_erng"},  32'(err_range), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_pc;
    int          xfers;
    int          stall_run;
    bit          exp_empty;
    int          n;

    rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h00E80820; mem[1] = 32'h00430824; mem[2] = 32'h00E80822;

    // Reset state
    repeat (2) cyc();
    check_reset_vals("rst");
    rst_n = 1'b1;
    cyc();

    // Straight-line run: first word after the third edge
    fetch_en = 1'b1; if_ready = 1'b1;
    cyc(); check_dat("start_e0_vld", 32'(if_valid), 32'd0);
    cyc(); check_dat("start_e1_vld", 32'(if_valid), 32'd0);
           check_dat("start_e1_addr", imem_addr, 32'h4);
    cyc(); expect_word("w0", 32'h0);
    cyc(); expect_word("w1", 32'h4);
    cyc(); expect_word("w2", 32'h8);
    cyc(); expect_word("w3", 32'hC);

    // Backpressure: head frozen, issue stops with two words held
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      expect_word("stall", 32'hC);
      check_dat("stall_addr", imem_addr, 32'h14);
    end
    if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      expect_word("resume", 32'h10 + 32'(4 * k));
    end

    // Redirect to 0x0C with 0x18 and 0x1C buffered
    if_ready = 1'b0;
    cyc(); expect_word("prered", 32'h18);
           check_dat("prered_addr", imem_addr, 32'h20);
    redirect_valid = 1'b1; redirect_pc = 32'hC; if_ready = 1'b1;
    cyc(); redirect_valid = 1'b0;
           check_dat("rd_r0_vld", 32'(if_valid), 32'd0);
           check_dat("rd_r0_addr", imem_addr, 32'hC);
    cyc(); check_dat("rd_r1_vld", 32'(if_valid), 32'd0);
    cyc(); expect_word("rd_tgt", 32'hC);
    cyc(); expect_word("rd_tgt1", 32'h10);

    // End of memory from 0xF4
    redirect_valid = 1'b1; redirect_pc = 32'hF4;
    cyc(); redirect_valid = 1'b0;
           check_dat("eom_r0_vld", 32'(if_valid), 32'd0);
    cyc(); check_dat("eom_r1_vld", 32'(if_valid), 32'd0);
    cyc(); expect_word("eom_f4", 32'hF4);
    cyc(); expect_word("eom_f8", 32'hF8);
           check_dat("eom_erng_early", 32'(err_range), 32'd0);
    cyc(); expect_word("eom_fc", 32'hFC);
           check_dat("eom_erng", 32'(err_range), 32'd1);
           check_dat("eom_addr", imem_addr, 32'h100);
    n = 0;
    while (!halted && n < 8) begin
      cyc();
      check_dat("eom_novld", 32'(if_valid), 32'd0);
      n++;
    end
    check_dat("eom_halted", 32'(halted), 32'd1);
    check_dat("eom_addr_hold", imem_addr, 32'h100);

    // Redirect ignored in HALT
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    cyc(); redirect_valid = 1'b0;
    cyc(); cyc();
    check_dat("halt_rd_halted", 32'(halted), 32'd1);
    check_dat("halt_rd_vld", 32'(if_valid), 32'd0);
    check_dat("halt_rd_addr", imem_addr, 32'h100);
    check_dat("halt_erng", 32'(err_range), 32'd1);

    // Asynchronous reset away from any clock edge, from HALT with err_range set
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst_halt");
    @(negedge clk); rst_n = 1'b1;

    // Restart at RESET_PC, then async reset mid-stream
    cyc(); cyc(); cyc(); expect_word("re_w0", 32'h0);
    cyc(); expect_word("re_w1", 32'h4);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst_run");
    @(negedge clk); rst_n = 1'b1;

    // Misaligned redirect
    cyc(); cyc(); cyc(); expect_word("mis_w0", 32'h0);
    check_dat("mis_pre_addr", imem_addr, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    cyc(); redirect_valid = 1'b0;
    check_dat("mis_emis", 32'(err_misaligned), 32'd1);
    check_dat("mis_halted", 32'(halted), 32'd1);
    check_dat("mis_vld", 32'(if_valid), 32'd0);
    check_dat("mis_addr", imem_addr, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    cyc(); redirect_valid = 1'b0;
    cyc(); cyc();
    check_dat("mis_late_halted", 32'(halted), 32'd1);
    check_dat("mis_late_vld", 32'(if_valid), 32'd0);
    check_dat("mis_late_addr", imem_addr, 32'h8);
    check_dat("mis_erng", 32'(err_range), 32'd0);

    // Randomized run against the stream model
    fetch_en = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; fetch_en = 1'b1;
    exp_pc = 32'h0; xfers = 0; stall_run = 0; exp_empty = 1'b0;
    cyc();
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (exp_empty) check_dat("rnd_flush_vld", 32'(if_valid), 32'd0);
      exp_empty = 1'b0;
      if (if_valid) begin
        check_dat("rnd_pc", if_pc, exp_pc);
        check_dat("rnd_instr", if_instr, word_at(exp_pc));
      end
      if (stall_run >= 3) check_dat("rnd_stall_addr", imem_addr, exp_pc + 32'h8);

      redirect_valid = 1'b0;
      if_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 24) == 0 || exp_pc >= 32'hC0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'($urandom_range(0, 47)) << 2;
        exp_pc         = redirect_pc;
        exp_empty      = 1'b1;
        stall_run      = 0;
      end else if (if_valid && if_ready) begin
        exp_pc    = exp_pc + 32'h4;
        xfers++;
        stall_run = 0;
      end else if (if_valid) begin
        stall_run++;
      end else begin
        stall_run = 0;
      end
    end
    redirect_valid = 1'b0;
    check_dat("rnd_progress", 32'(xfers > 1000), 32'd1);
    check_dat("rnd_no_err", {30'b0, err_misaligned, err_range}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer between the program counter logic and the byte-addressed, synchronous-read instruction memory (256 bytes, 32-bit little-endian words, one registered read per `clk` edge, no enable). It owns the fetch PC, issues one word read per cycle, and absorbs the memory's one-cycle read latency with a 2-entry skid buffer. It presents instructions to the IF/ID stage over a valid/ready handshake and handles branch/jump redirects, misaligned targets and end-of-memory.

## Interface
- `RESET_PC`, 32'h0: first fetch address after `fetch_en`.
- `MEM_BYTES`, 256: instruction memory size in bytes. Valid word addresses are 0..MEM_BYTES-4.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_en`  in  1  leaves IDLE. Level-sampled.
- `imem_addr`  out  32  byte address presented to the instruction memory, registered (`pc_q`).
- `imem_instr`  in  32  memory read data. Valid in the cycle after `imem_addr` was held.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a fetched word.
- `if_ready`  in  1  IF/ID accepts. Transfer happens when `if_valid & if_ready`.
- `if_instr`  out  32  instruction word.
- `if_pc`  out  32  byte address of `if_instr`.
- `redirect_valid`  in  1  branch/jump taken. Single-cycle pulse.
- `redirect_pc`  in  32  target byte address.
- `halted`  out  1  state is HALT.
- `err_misaligned`  out  1  sticky: redirect target had `[1:0] != 0`.
- `err_range`  out  1  sticky: fetch reached `pc_q > MEM_BYTES-4`.

## Operation
- States:
  - IDLE: no issue. Goes to RUN when `fetch_en` is high.
  - RUN: issues fetches (rules below).
  - DRAIN: no new issue; buffered words still deliver.
  - HALT: terminal until reset.
- Issue rule, evaluated in RUN each cycle:
  - `pop = if_valid & if_ready`.
  - Issue when `count + inflight_v - pop <= 1`.
  - On issue: `inflight_v <= 1`, `inflight_pc <= pc_q`, `pc_q <= pc_q + 4`.
  - Otherwise `inflight_v <= 0` and `pc_q` holds.
- Return: when `inflight_v` is high, `{imem_instr, inflight_pc}` is pushed into the FIFO that cycle. The issue rule guarantees no overflow, including simultaneous push and pop.
- Output: `if_valid/if_instr/if_pc` come from the FIFO head, driven from registers. The head holds stable while `if_valid & !if_ready`.
- Range: in RUN, if `pc_q > MEM_BYTES-4`:
  - do not issue;
  - set `err_range`;
  - go to DRAIN.
- DRAIN: goes to HALT when `count == 0` and `inflight_v == 0`.
- Redirect, accepted in RUN or DRAIN; highest priority:
  - flush the FIFO (`count <= 0`) and set `inflight_v <= 0`;
  - discard any pop that cycle;
  - if `redirect_pc[1:0] == 0`: `pc_q <= redirect_pc`, state goes to RUN;
  - otherwise: set `err_misaligned`, state goes to HALT, `pc_q` holds.
- Redirect is ignored in IDLE and HALT. `fetch_en` is ignored outside IDLE.
- Arithmetic: `pc_q + 4` is a 32-bit modulo add. The range check catches an address past the end of memory before any wrap matters.

## Timing
- Reset values:
  - `pc_q` (`imem_addr`) = `RESET_PC`;
  - state IDLE;
  - `count` = 0, `inflight_v` = 0;
  - `if_valid` = 0, `if_instr` = 0, `if_pc` = 0;
  - `halted` = 0, `err_*` = 0.
- Reset asserted mid-operation returns all of the above at once, without waiting for a clock.
- Start: `fetch_en` sampled at edge E0. First issue at E1, push at E2, `if_valid` = 1 after E2 (cycle 3 after the sampling edge).
- Redirect sampled at edge R:
  - `if_valid` = 0 after R;
  - target read issued at R+1;
  - target word visible after R+2.
  - No word fetched before R is ever presented after R.
- Steady state with `if_ready` held high: one instruction per cycle.
- Stall: with `if_ready` low, at most 2 words are buffered and issue stops. After `if_ready` rises, throughput is back to one per cycle with no bubble.

## Structure
- Package `imem_fetch_pkg`: state enum {IDLE, RUN, DRAIN, HALT}, `INSTR_W = 32`, `ADDR_W = 32`, `PC_STEP = 4`.
- Sub-module `fetch_skid_fifo`: 2-entry FIFO of {pc, instr} with registered head outputs, push/pop/flush, and a 2-bit `count`.
- Top level holds the FSM, `pc_q`, inflight tracking and the error flags.

## Test plan
- Straight-line run: memory holds 0x00E80820, 0x00430824, 0x00E80822 at bytes 0/4/8; `fetch_en` = 1, `if_ready` = 1 -> `if_pc` 0, 4, 8 on consecutive cycles starting in cycle 3, matching words in order.
- Backpressure: drop `if_ready` for 5 cycles mid-stream -> `if_pc` stays frozen and no word is lost or duplicated; issue stops after 2 words are buffered.
- Redirect: redirect to 0x0C while words 4 and 8 are buffered/inflight -> neither 4 nor 8 appears; next `if_pc` = 0x0C, 2 cycles after redirect.
- Misaligned: `redirect_pc` = 0x06 -> `err_misaligned` = 1, `halted` = 1, `if_valid` = 0 from then on; a later `redirect_valid` is ignored.
- End of memory: run from 0xF4 with `MEM_BYTES` = 256 -> words 0xF4, 0xF8, 0xFC delivered, then `err_range` = 1; `halted` = 1 once drained; `imem_addr` stays 0x100.
- Async reset asserted mid-stream without a clock edge -> all outputs return immediately to their reset values; re-run of `fetch_en` restarts fetching at `RESET_PC`.
